apb_slave_module: RTL and testbench



---
 rtl/apb_slave_module_pkg.sv | 25 ++
 rtl/apb_slave_module_decode.sv | 34 +++
 rtl/apb_slave_module.sv | 132 +++++++++++++
 tb/tb_apb_slave_module.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_module_pkg.sv
// rtl/apb_slave_module_pkg.sv - shared constants for the APB front end of the matrix-multiplier accelerator
//
// Holds the register offsets, the 2-bit FSM state encoding and the strobe-width
// derivation shared by apb_slave_module and apb_decode_module.
package apb_slave_module_pkg;

    // Register offsets, taken from paddr[4:0]
    localparam logic [4:0] OFF_CONTROL   = 5'h00;
    localparam logic [4:0] OFF_OPERAND_A = 5'h04;
    localparam logic [4:0] OFF_OPERAND_B = 5'h08;
    localparam logic [4:0] OFF_FLAGS     = 5'h0C;
    localparam logic [4:0] OFF_SP        = 5'h10;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Number of matrix elements carried per bus word (strobe width)
    function automatic int calc_max_dim(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

endpackage

// File: rtl/apb_slave_module_decode.sv
// rtl/apb_slave_module_decode.sv - register offset decoder for the APB front end
//
// Ports:
//   offset_i     register offset (paddr[4:0])
//   pwrite_i     access direction, 1 = write
//   busy_i       accelerator running
//   legal_o      offset maps to an existing register
//   read_only_o  access is a write to a register the bus may only read
//   locked_o     access is a write to a configuration register while running
module apb_decode_module
    import apb_slave_module_pkg::*;
(
    input  logic [4:0] offset_i,
    input  logic       pwrite_i,
    input  logic       busy_i,
    output logic       legal_o,
    output logic       read_only_o,
    output logic       locked_o
);

    logic w_is_cfg;
    logic w_is_status;

    always_comb begin
        w_is_cfg    = (offset_i == OFF_CONTROL) || (offset_i == OFF_OPERAND_A) ||
                      (offset_i == OFF_OPERAND_B);
        w_is_status = (offset_i == OFF_FLAGS) || (offset_i == OFF_SP);
        legal_o     = w_is_cfg || w_is_status;
        read_only_o = pwrite_i && w_is_status;
        // Configuration registers must not change under a running computation
        locked_o    = pwrite_i && busy_i && w_is_cfg;
    end

endmodule

// File: rtl/apb_slave_module.sv
// rtl/apb_slave_module.sv - APB slave converting host accesses into register-file access strobes
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   psel_i, penable_i, pwrite_i        APB control
//   paddr_i, pwdata_i, pstrb_i         APB address, write data, per-element strobe
//   busy_i                             accelerator running
//   rf_data_i                          combinational read data from the register file
//   prdata_o, pready_o, pslverr_o      APB response
//   address_o, data_o                  register-file address and write data
//   write_enable_o, strobe_o           register-file write pulse and element strobe
module apb_slave_module
    import apb_slave_module_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  BUS_WIDTH  = 64,
    parameter int  ADDR_WIDTH = 32,
    localparam int MAX_DIM    = calc_max_dim(BUS_WIDTH, DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [BUS_WIDTH-1:0]  pwdata_i,
    input  logic [MAX_DIM-1:0]    pstrb_i,
    input  logic                  busy_i,
    input  logic [BUS_WIDTH-1:0]  rf_data_i,
    output logic [BUS_WIDTH-1:0]  prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic [BUS_WIDTH-1:0]  data_o,
    output logic                  write_enable_o,
    output logic [MAX_DIM-1:0]    strobe_o
);

    logic [1:0]            r_state;
    logic                  r_err;
    logic [BUS_WIDTH-1:0]  r_prdata;
    logic                  r_pready;
    logic                  r_pslverr;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [BUS_WIDTH-1:0]  r_data;
    logic                  r_write_enable;
    logic [MAX_DIM-1:0]    r_strobe;

    logic w_legal;
    logic w_read_only;
    logic w_locked;
    logic w_err;
    logic w_setup;

    apb_decode_module u_decode (
        .offset_i    (paddr_i[4:0]),
        .pwrite_i    (pwrite_i),
        .busy_i      (busy_i),
        .legal_o     (w_legal),
        .read_only_o (w_read_only),
        .locked_o    (w_locked)
    );

    assign w_err   = !w_legal || w_read_only || w_locked;
    // penable_i high while idle is a protocol violation and is not a setup phase
    assign w_setup = psel_i && !penable_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= ST_IDLE;
            r_err          <= 1'b0;
            r_prdata       <= '0;
            r_pready       <= 1'b0;
            r_pslverr      <= 1'b0;
            r_address      <= '0;
            r_data         <= '0;
            r_write_enable <= 1'b0;
            r_strobe       <= '0;
        end else begin
            r_write_enable <= 1'b0;
            r_pready       <= 1'b0;
            r_pslverr      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_setup) begin
                        r_address      <= paddr_i;
                        r_data         <= pwdata_i;
                        r_strobe       <= pstrb_i;
                        r_err          <= w_err;
                        // Registered here so the pulse occupies exactly the WRITE cycle
                        r_write_enable <= pwrite_i && !w_err;
                        r_state        <= pwrite_i ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (!psel_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_pready  <= 1'b1;
                        r_pslverr <= r_err;
                        r_state   <= ST_RESP;
                    end
                end
                ST_READ: begin
                    if (!psel_i) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_prdata  <= r_err ? '0 : rf_data_i;
                        r_pready  <= 1'b1;
                        r_pslverr <= r_err;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign prdata_o       = r_prdata;
    assign pready_o       = r_pready;
    assign pslverr_o      = r_pslverr;
    assign address_o      = r_address;
    assign data_o         = r_data;
    assign write_enable_o = r_write_enable;
    assign strobe_o       = r_strobe;

endmodule

// File: tb/tb_apb_slave_module.sv
// tb/tb_apb_slave_module.sv - self-checking randomized bench for apb_slave_module
module tb_apb_slave_module;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [31:0] paddr_i;
    logic [63:0] pwdata_i;
    logic [1:0]  pstrb_i;
    logic        busy_i;
    logic [63:0] rf_data_i;
    logic [63:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic [31:0] address_o;
    logic [63:0] data_o;
    logic        write_enable_o;
    logic [1:0]  strobe_o;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: what the bus-visible outputs should be holding
    logic [63:0] exp_prdata = '0;
    logic [31:0] exp_addr   = '0;
    logic [63:0] exp_data   = '0;
    logic [1:0]  exp_strb   = '0;

    apb_slave_module dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .psel_i         (psel_i),
        .penable_i      (penable_i),
        .pwrite_i       (pwrite_i),
        .paddr_i        (paddr_i),
        .pwdata_i       (pwdata_i),
        .pstrb_i        (pstrb_i),
        .busy_i         (busy_i),
        .rf_data_i      (rf_data_i),
        .prdata_o       (prdata_o),
        .pready_o       (pready_o),
        .pslverr_o      (pslverr_o),
        .address_o      (address_o),
        .data_o         (data_o),
        .write_enable_o (write_enable_o),
        .strobe_o       (strobe_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Register map rules: five word-aligned registers at 0x00..0x10, the top two
    // (FLAGS, SP) readable only; writes to the rest refused while running.
    function automatic bit model_err(input logic [31:0] a, input bit wr, input bit busy);
        int off;
        bit exists;
        off    = int'(a[4:0]);
        exists = (off % 4 == 0) && (off <= 16);
        return !exists || (wr && (off >= 12 || busy));
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic go_idle(input int n);
        psel_i    = 1'b0;
        penable_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            chk("idle_rdy", pready_o, 1'b0);
            chk("idle_we", write_enable_o, 1'b0);
        end
    endtask

    // One complete transfer starting in the current cycle (T0 = setup).
    task automatic xfer(input bit wr, input logic [31:0] a, input logic [63:0] wd,
                        input logic [1:0] st, input bit busy, input logic [63:0] rd,
                        input bit abort);
        bit e;
        e = model_err(a, wr, busy);
        psel_i    = 1'b1;
        penable_i = 1'b0;
        pwrite_i  = wr;
        paddr_i   = a;
        pwdata_i  = wd;
        pstrb_i   = st;
        busy_i    = busy;
        rf_data_i = {$urandom, $urandom};
        exp_addr  = a;
        exp_data  = wd;
        exp_strb  = st;
        step();
        // T1
        chk("t1_we", write_enable_o, wr && !e);
        chk("t1_addr", address_o, exp_addr);
        chk("t1_data", data_o, exp_data);
        chk("t1_strb", strobe_o, exp_strb);
        chk("t1_rdy", pready_o, 1'b0);
        penable_i = 1'b1;
        if (abort) psel_i = 1'b0;
        busy_i    = 1'($urandom);
        pwdata_i  = {$urandom, $urandom};
        paddr_i   = $urandom;
        rf_data_i = rd;
        step();
        // T2
        if (!abort) begin
            if (!wr) exp_prdata = e ? 64'd0 : rd;
            chk("t2_rdy", pready_o, 1'b1);
            chk("t2_err", pslverr_o, e);
        end else begin
            chk("abort_rdy", pready_o, 1'b0);
            chk("abort_err", pslverr_o, 1'b0);
        end
        chk("t2_prdata", prdata_o, exp_prdata);
        chk("t2_we", write_enable_o, 1'b0);
        chk("t2_addr", address_o, exp_addr);
        rf_data_i = {$urandom, $urandom};
        step();
        // T3: DUT back in IDLE, ready for the next setup
        chk("t3_rdy", pready_o, 1'b0);
        chk("t3_we", write_enable_o, 1'b0);
        chk("t3_prdata", prdata_o, exp_prdata);
    endtask

    initial begin
        logic [31:0] a;
        rst_ni    = 1'b0;
        psel_i    = 1'b0;
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
        paddr_i   = '0;
        pwdata_i  = '0;
        pstrb_i   = '0;
        busy_i    = 1'b0;
        rf_data_i = '0;
        repeat (3) step();
        chk("rst_prdata", prdata_o, 64'd0);
        chk("rst_rdy", pready_o, 1'b0);
        chk("rst_err", pslverr_o, 1'b0);
        chk("rst_addr", address_o, 32'd0);
        chk("rst_data", data_o, 64'd0);
        chk("rst_we", write_enable_o, 1'b0);
        chk("rst_strb", strobe_o, 2'd0);
        rst_ni = 1'b1;
        go_idle(2);

        // Directed cases
        xfer(1'b1, 32'h24, 64'h00000005_00000003, 2'b11, 1'b0, 64'h0, 1'b0);
        xfer(1'b0, 32'h00, 64'h0, 2'b00, 1'b0, 64'h1234, 1'b0);
        xfer(1'b1, 32'h10, 64'hdead, 2'b11, 1'b0, 64'h0, 1'b0);
        xfer(1'b0, 32'h14, 64'h0, 2'b00, 1'b0, 64'h5555, 1'b0);
        xfer(1'b1, 32'h08, 64'h77, 2'b01, 1'b1, 64'h0, 1'b0);
        xfer(1'b0, 32'h10, 64'h0, 2'b00, 1'b1, 64'habcd, 1'b0);
        xfer(1'b1, 32'h04, 64'h0, 2'b00, 1'b0, 64'h0, 1'b0);
        // Back-to-back write then read of the same register
        xfer(1'b1, 32'h04, 64'h1111_2222_3333_4444, 2'b11, 1'b0, 64'h0, 1'b0);
        xfer(1'b0, 32'h04, 64'h0, 2'b00, 1'b0, 64'h1111_2222_3333_4444, 1'b0);
        // Abort a read in T1, then a normal transfer
        xfer(1'b0, 32'h0C, 64'h0, 2'b00, 1'b0, 64'h9999, 1'b1);
        xfer(1'b0, 32'h0C, 64'h0, 2'b00, 1'b0, 64'h8888, 1'b0);
        go_idle(1);

        // penable_i high while idle must capture nothing
        psel_i    = 1'b1;
        penable_i = 1'b1;
        pwrite_i  = 1'b1;
        paddr_i   = 32'h4;
        pwdata_i  = 64'hfeed;
        step();
        step();
        chk("viol_we", write_enable_o, 1'b0);
        chk("viol_addr", address_o, exp_addr);
        chk("viol_rdy", pready_o, 1'b0);
        go_idle(1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0)
                a = $urandom;
            else
                a = {$urandom_range(0, 1023), 5'($urandom_range(0, 7) * 4)};
            xfer(1'($urandom), a, {$urandom, $urandom}, 2'($urandom), 1'($urandom),
                 {$urandom, $urandom}, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) go_idle($urandom_range(1, 2));
        end

        // Asynchronous reset in the middle of a write
        psel_i    = 1'b1;
        penable_i = 1'b0;
        pwrite_i  = 1'b1;
        paddr_i   = 32'h8;
        pwdata_i  = 64'h42;
        pstrb_i   = 2'b11;
        busy_i    = 1'b0;
        step();
        chk("pre_rst_we", write_enable_o, 1'b1);
        penable_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_we", write_enable_o, 1'b0);
        chk("arst_addr", address_o, 32'd0);
        chk("arst_data", data_o, 64'd0);
        chk("arst_strb", strobe_o, 2'd0);
        chk("arst_prdata", prdata_o, 64'd0);
        chk("arst_rdy", pready_o, 1'b0);
        step();
        rst_ni     = 1'b1;
        exp_prdata = '0;
        go_idle(3);
        chk("post_rst_prdata", prdata_o, 64'd0);
        xfer(1'b0, 32'h00, 64'h0, 2'b00, 1'b0, 64'h600d, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
